// File: rtl/maxpool_window_counter.sv
// Raster-order pixel position tracker for a POOL_W x POOL_H max-pool window over an IMG_W x IMG_H map.
// Latency: decoded position outputs describe the pixel presented this cycle; frame_done_o is a registered pulse one cycle after the last pixel.
// Backpressure: none; en_i accepts one pixel per cycle and state holds while en_i is low. clr_i has priority over en_i.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous reset, active low
//   clr_i          synchronous clear to frame start (wins over en_i)
//   en_i           one pixel accepted this cycle
//   col_idx_o      column of current pixel, 0..IMG_W-1
//   row_idx_o      row of current pixel, 0..IMG_H-1
//   col_first_o    current pixel is column phase 0 of a full window
//   col_last_o     current pixel is column phase POOL_W-1 of a full window
//   row_first_o    current row is row phase 0 of a full window
//   row_last_o     current row is row phase POOL_H-1 of a full window
//   pool_valid_o   en_i & col_last_o & row_last_o
//   out_idx_o      pooled column index, 0..IMG_W/POOL_W-1
//   frame_done_o   one-cycle pulse after the last pixel of a frame
module maxpool_window_counter #(
  parameter int IDX_WIDTH = 14,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int POOL_W    = 2,
  parameter int POOL_H    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [IDX_WIDTH-1:0] col_idx_o,
  output logic [IDX_WIDTH-1:0] row_idx_o,
  output logic                 col_first_o,
  output logic                 col_last_o,
  output logic                 row_first_o,
  output logic                 row_last_o,
  output logic                 pool_valid_o,
  output logic [IDX_WIDTH-1:0] out_idx_o,
  output logic                 frame_done_o
);

  // Columns/rows at or beyond the last complete window form a ragged edge.
  localparam int COL_FULL = (IMG_W / POOL_W) * POOL_W;
  localparam int ROW_FULL = (IMG_H / POOL_H) * POOL_H;

  localparam logic [IDX_WIDTH-1:0] COL_MAX       = IDX_WIDTH'(IMG_W - 1);
  localparam logic [IDX_WIDTH-1:0] ROW_MAX       = IDX_WIDTH'(IMG_H - 1);
  localparam logic [IDX_WIDTH-1:0] CPH_MAX       = IDX_WIDTH'(POOL_W - 1);
  localparam logic [IDX_WIDTH-1:0] RPH_MAX       = IDX_WIDTH'(POOL_H - 1);
  localparam logic [IDX_WIDTH-1:0] COL_FULL_V    = IDX_WIDTH'(COL_FULL);
  localparam logic [IDX_WIDTH-1:0] ROW_FULL_V    = IDX_WIDTH'(ROW_FULL);
  localparam logic [IDX_WIDTH-1:0] COL_FULL_LAST = IDX_WIDTH'(COL_FULL - 1);

  logic [IDX_WIDTH-1:0] col_q, col_d;
  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic [IDX_WIDTH-1:0] cph_q, cph_d;
  logic [IDX_WIDTH-1:0] rph_q, rph_d;
  logic [IDX_WIDTH-1:0] oidx_q, oidx_d;
  logic                 fd_q, fd_d;

  logic col_end, row_end, cph_end, rph_end;
  logic col_in_full, row_in_full;

  assign col_end     = (col_q == COL_MAX);
  assign row_end     = (row_q == ROW_MAX);
  assign cph_end     = (cph_q == CPH_MAX);
  assign rph_end     = (rph_q == RPH_MAX);
  assign col_in_full = (col_q < COL_FULL_V);
  assign row_in_full = (row_q < ROW_FULL_V);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    cph_d  = cph_q;
    rph_d  = rph_q;
    oidx_d = oidx_q;
    fd_d   = 1'b0;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      cph_d  = '0;
      rph_d  = '0;
      oidx_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d  = '0;
        cph_d  = '0;
        oidx_d = '0;
        if (row_end) begin
          row_d = '0;
          rph_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
          rph_d = rph_end ? '0 : rph_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
        cph_d = cph_end ? '0 : cph_q + 1'b1;
        // Leaving the last full window must not step into a non-existent
        // pooled column: the index freezes across the ragged edge.
        if (cph_end && (col_q != COL_FULL_LAST)) begin
          oidx_d = oidx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      cph_q  <= '0;
      rph_q  <= '0;
      oidx_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      cph_q  <= cph_d;
      rph_q  <= rph_d;
      oidx_q <= oidx_d;
      fd_q   <= fd_d;
    end
  end

  assign col_idx_o    = col_q;
  assign row_idx_o    = row_q;
  assign out_idx_o    = oidx_q;
  assign frame_done_o = fd_q;
  assign col_first_o  = col_in_full && (cph_q == '0);
  assign col_last_o   = col_in_full && cph_end;
  assign row_first_o  = row_in_full && (rph_q == '0);
  assign row_last_o   = row_in_full && rph_end;
  assign pool_valid_o = en_i && col_last_o && row_last_o;

endmodule

// File: tb/tb_maxpool_window_counter.sv
module tb_maxpool_window_counter;

  localparam int IW = 14;

  // Configurations of the three instances: width, height, pool width, pool height.
  function automatic int cfg_w(int k);
    case (k) 0: return 28; 1: return 5; default: return 9; endcase
  endfunction
  function automatic int cfg_h(int k);
    case (k) 0: return 28; 1: return 5; default: return 3; endcase
  endfunction
  function automatic int cfg_pw(int k);
    case (k) 0: return 2; 1: return 2; default: return 3; endcase
  endfunction
  function automatic int cfg_ph(int k);
    case (k) 0: return 2; 1: return 2; default: return 1; endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic [2:0] clr;

  logic [IW-1:0] col_o [3];
  logic [IW-1:0] row_o [3];
  logic [IW-1:0] oi_o  [3];
  logic          cf_o  [3];
  logic          cl_o  [3];
  logic          rf_o  [3];
  logic          rl_o  [3];
  logic          pv_o  [3];
  logic          fd_o  [3];

  always #5 clk = ~clk;

  maxpool_window_counter #(.IDX_WIDTH(IW), .IMG_W(28), .IMG_H(28), .POOL_W(2), .POOL_H(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .en_i(en[0]),
    .col_idx_o(col_o[0]), .row_idx_o(row_o[0]), .col_first_o(cf_o[0]), .col_last_o(cl_o[0]),
    .row_first_o(rf_o[0]), .row_last_o(rl_o[0]), .pool_valid_o(pv_o[0]), .out_idx_o(oi_o[0]),
    .frame_done_o(fd_o[0]));

  maxpool_window_counter #(.IDX_WIDTH(IW), .IMG_W(5), .IMG_H(5), .POOL_W(2), .POOL_H(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .en_i(en[1]),
    .col_idx_o(col_o[1]), .row_idx_o(row_o[1]), .col_first_o(cf_o[1]), .col_last_o(cl_o[1]),
    .row_first_o(rf_o[1]), .row_last_o(rl_o[1]), .pool_valid_o(pv_o[1]), .out_idx_o(oi_o[1]),
    .frame_done_o(fd_o[1]));

  maxpool_window_counter #(.IDX_WIDTH(IW), .IMG_W(9), .IMG_H(3), .POOL_W(3), .POOL_H(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[2]), .en_i(en[2]),
    .col_idx_o(col_o[2]), .row_idx_o(row_o[2]), .col_first_o(cf_o[2]), .col_last_o(cl_o[2]),
    .row_first_o(rf_o[2]), .row_last_o(rl_o[2]), .pool_valid_o(pv_o[2]), .out_idx_o(oi_o[2]),
    .frame_done_o(fd_o[2]));

  // Reference model: linear pixel number within the frame plus the pending frame-done flag.
  int p   [3];
  bit mfd [3];

  int tests = 0;
  int fails = 0;
  int pv_cnt [3];
  int fd_cnt [3];
  int bad_pv = 0;

  typedef struct {
    logic en;
    logic clr;
    int   col;
    int   row;
    logic cf;
    logic cl;
    logic rf;
    logic rl;
    int   oi;
    logic pv;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      p[k]   = 0;
      mfd[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clr[k]) begin
        p[k]   = 0;
        mfd[k] = 1'b0;
      end else if (en[k]) begin
        mfd[k] = (p[k] == cfg_w(k) * cfg_h(k) - 1);
        p[k]   = (p[k] + 1) % (cfg_w(k) * cfg_h(k));
      end else begin
        mfd[k] = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      int c, r, cfull, rfull, eoi;
      bit ecf, ecl, erf, erl, epv;
      c     = p[k] % cfg_w(k);
      r     = p[k] / cfg_w(k);
      cfull = (cfg_w(k) / cfg_pw(k)) * cfg_pw(k);
      rfull = (cfg_h(k) / cfg_ph(k)) * cfg_ph(k);
      ecf   = (c < cfull) && (c % cfg_pw(k) == 0);
      ecl   = (c < cfull) && (c % cfg_pw(k) == cfg_pw(k) - 1);
      erf   = (r < rfull) && (r % cfg_ph(k) == 0);
      erl   = (r < rfull) && (r % cfg_ph(k) == cfg_ph(k) - 1);
      eoi   = (c < cfull) ? c / cfg_pw(k) : cfg_w(k) / cfg_pw(k) - 1;
      epv   = en[k] && ecl && erl;
      tests++;
      if (int'(col_o[k]) != c || int'(row_o[k]) != r || int'(oi_o[k]) != eoi ||
          cf_o[k] !== ecf || cl_o[k] !== ecl || rf_o[k] !== erf || rl_o[k] !== erl ||
          pv_o[k] !== epv || fd_o[k] !== mfd[k]) begin
        fails++;
        $display("FAIL model_dut%0d: got col=%0d row=%0d cf,cl,rf,rl,pv,fd=%b%b%b%b%b%b oi=%0d; expected col=%0d row=%0d cf,cl,rf,rl,pv,fd=%b%b%b%b%b%b oi=%0d",
                 k, col_o[k], row_o[k], cf_o[k], cl_o[k], rf_o[k], rl_o[k], pv_o[k], fd_o[k], oi_o[k],
                 c, r, ecf, ecl, erf, erl, epv, mfd[k], eoi);
      end
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    check_model();
    for (int k = 0; k < 3; k++) begin
      if (pv_o[k] === 1'b1) pv_cnt[k]++;
      if (fd_o[k] === 1'b1) fd_cnt[k]++;
    end
    if (pv_o[0] === 1'b1 && (col_o[0][0] == 1'b0 || row_o[0][0] == 1'b0)) bad_pv++;
  endtask

  task automatic to_posedge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    to_negedge();
    to_posedge();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 3; k++) begin
      pv_cnt[k] = 0;
      fd_cnt[k] = 0;
    end
    bad_pv = 0;
  endtask

  // Called at posedge+1: pulses reset in the middle of the cycle.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 5x5 map, 2x2 window, starting from frame start.
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    clear_counts();
    rst_n = 1'b0;
    en    = 3'b000;
    clr   = 3'b000;
    model_reset();

    // Reset state.
    #2;
    check_model();
    chk("rst_col_first0", int'(cf_o[0]), 1);
    chk("rst_row_first0", int'(rf_o[0]), 1);
    chk("rst_col_last0", int'(cl_o[0]), 0);
    chk("rst_col_last2", int'(cl_o[2]), 0);
    chk("rst_row_last2", int'(rl_o[2]), 1);
    chk("rst_frame_done0", int'(fd_o[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table on the 5x5 instance, including ragged column and clear.
    for (int i = 0; i < 13; i++) begin
      en[1]  = tbl[i].en;
      clr[1] = tbl[i].clr;
      to_negedge();
      tests++;
      if (int'(col_o[1]) != tbl[i].col || int'(row_o[1]) != tbl[i].row || int'(oi_o[1]) != tbl[i].oi ||
          cf_o[1] !== tbl[i].cf || cl_o[1] !== tbl[i].cl || rf_o[1] !== tbl[i].rf ||
          rl_o[1] !== tbl[i].rl || pv_o[1] !== tbl[i].pv) begin
        fails++;
        $display("FAIL table[%0d]: got col=%0d row=%0d cf,cl,rf,rl,pv=%b%b%b%b%b oi=%0d; expected col=%0d row=%0d cf,cl,rf,rl,pv=%b%b%b%b%b oi=%0d",
                 i, col_o[1], row_o[1], cf_o[1], cl_o[1], rf_o[1], rl_o[1], pv_o[1], oi_o[1],
                 tbl[i].col, tbl[i].row, tbl[i].cf, tbl[i].cl, tbl[i].rf, tbl[i].rl, tbl[i].pv, tbl[i].oi);
      end
      to_posedge();
    end
    en  = 3'b000;
    clr = 3'b000;

    // Full 5x5 frame: four complete windows, one frame-done pulse.
    mid_reset();
    clear_counts();
    en = 3'b010;
    for (int i = 0; i < 25; i++) cycle();
    en = 3'b000;
    cycle();
    chk("pv_count_5x5", pv_cnt[1], 4);
    chk("fd_count_5x5", fd_cnt[1], 1);

    // Two back-to-back 28x28 frames with en held high.
    mid_reset();
    clear_counts();
    en = 3'b001;
    for (int i = 0; i < 785; i++) cycle();
    chk("pv_count_frame1", pv_cnt[0], 196);
    chk("fd_count_frame1", fd_cnt[0], 1);
    for (int i = 0; i < 783; i++) cycle();
    en = 3'b000;
    cycle();
    chk("pv_count_frame2", pv_cnt[0], 392);
    chk("fd_count_frame2", fd_cnt[0], 2);
    chk("pv_odd_positions", bad_pv, 0);

    // Clear together with enable at pixel (10,3).
    mid_reset();
    en = 3'b001;
    for (int i = 0; i < 94; i++) cycle();
    clr = 3'b001;
    to_negedge();
    chk("pre_clr_col", int'(col_o[0]), 10);
    chk("pre_clr_row", int'(row_o[0]), 3);
    to_posedge();
    clr = 3'b000;
    en  = 3'b000;
    to_negedge();
    chk("post_clr_col", int'(col_o[0]), 0);
    chk("post_clr_row", int'(row_o[0]), 0);
    chk("post_clr_pv", int'(pv_o[0]), 0);
    chk("post_clr_fd", int'(fd_o[0]), 0);
    to_posedge();

    // Async reset right after the last pixel of the frame was accepted.
    en = 3'b001;
    for (int i = 0; i < 784; i++) cycle();
    chk("pre_rst_fd", int'(fd_o[0]), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_fd", int'(fd_o[0]), 0);
    chk("async_rst_col", int'(col_o[0]), 0);
    chk("async_rst_row", int'(row_o[0]), 0);
    chk("async_rst_cf", int'(cf_o[0]), 1);
    rst_n = 1'b1;
    cycle();
    cycle();

    // Random enables and occasional clears on all three instances.
    mid_reset();
    for (int i = 0; i < 3000; i++) begin
      en = 3'($urandom);
      for (int k = 0; k < 3; k++) clr[k] = ($urandom_range(0, 63) == 0);
      cycle();
    end
    en  = 3'b000;
    clr = 3'b000;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
